updown_counter_param: RTL and testbench

//  Parametrised up/down counter with active-low load and runtime-programmable limits [lim_lo, lim_hi].
//  Two modes: wrap or saturate at the limits. Registered terminal-count pulse.

---
 rtl/updown_counter_param_pkg.sv | 25 ++
 rtl/updown_counter_param_if.sv | 43 ++++
 rtl/updown_counter_param_prescaler.sv | 37 +++
 rtl/updown_counter_param.sv | 124 ++++++++++++
 tb/tb_updown_counter_param.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared types and helpers for the up/down counter family.
// Holds the wrap/saturate mode encoding and the limit clamp used by loads and limit changes.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int CLAMP_W = 64;

  // Callers zero-extend to CLAMP_W and truncate the result back to their own width.
  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] val,
                                               input logic [CLAMP_W-1:0] lo,
                                               input logic [CLAMP_W-1:0] hi);
    if (val < lo) begin
      return lo;
    end
    if (val > hi) begin
      return hi;
    end
    return val;
  endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// Control/status bundle of the up/down counter; the slave modport is the counter side.
// presc_div and PRESC_W exist only when COUNTER_PRESCALE_EN is defined.
interface updown_counter_param_if #(
  parameter int WIDTH = 16
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESC_W = 4
`endif
);

  logic                 ld_cnt;
  logic [WIDTH-1:0]     data_in;
  logic                 count_enb;
  logic                 updn_cnt;
  counter_pkg::mode_e   mode;
  logic                 lim_wr;
  logic [WIDTH-1:0]     lim_lo_in;
  logic [WIDTH-1:0]     lim_hi_in;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0]   presc_div;
`endif
  logic [WIDTH-1:0]     data_out;
  logic                 at_max;
  logic                 at_min;
  logic                 tc;
  logic                 lim_err;

  modport master (
    output ld_cnt, data_in, count_enb, updn_cnt, mode, lim_wr, lim_lo_in, lim_hi_in,
`ifdef COUNTER_PRESCALE_EN
    output presc_div,
`endif
    input  data_out, at_max, at_min, tc, lim_err
  );

  modport slave (
    input  ld_cnt, data_in, count_enb, updn_cnt, mode, lim_wr, lim_lo_in, lim_hi_in,
`ifdef COUNTER_PRESCALE_EN
    input  presc_div,
`endif
    output data_out, at_max, at_min, tc, lim_err
  );

endinterface

// File: rtl/updown_counter_param_prescaler.sv
// Step prescaler: counts enabled cycles 0..div and ticks on the wrapping cycle.
// Only built when COUNTER_PRESCALE_EN is defined.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               enb,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = enb && !clr && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enb) begin
      cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/updown_counter_param.sv
// Up/down counter with programmable limits, wrap/saturate modes and a registered tc pulse.
// Define COUNTER_PRESCALE_EN to gate counting through counter_prescaler (adds presc_div).
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_LO  = '0,
  parameter logic [WIDTH-1:0] RST_HI  = '1,
  parameter int               PRESC_W = 4
) (
  input logic                   clk,
  input logic                   rst_,
  updown_counter_param_if.slave bus
);

  if (WIDTH < 2 || PRESC_W < 1) begin : gBadParams
    $error("updown_counter_param: WIDTH must be >= 2 and PRESC_W >= 1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;
  logic             satHold_q, satHold_d;
  logic             dir_q;
  mode_e            mode_q;
  logic             tick;
  logic             holdEff;
  logic             inRange;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(.PRESC_W(PRESC_W)) uPresc (
    .clk  (clk),
    .rst_ (rst_),
    .enb  (bus.count_enb),
    .clr  (!bus.ld_cnt),
    .div  (bus.presc_div),
    .tick (tick)
  );
`else
  assign tick = bus.count_enb;
`endif

  // A change of direction or mode since last cycle re-arms the saturation tc pulse.
  always_comb begin
    holdEff   = satHold_q && (bus.updn_cnt == dir_q) && (bus.mode == mode_q);
    inRange   = (cnt_q >= lo_q) && (cnt_q <= hi_q);
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    tc_d      = 1'b0;
    err_d     = err_q;
    satHold_d = holdEff;

    if (!bus.ld_cnt) begin
      cnt_d     = WIDTH'(clamp(CLAMP_W'(bus.data_in), CLAMP_W'(lo_q), CLAMP_W'(hi_q)));
      satHold_d = 1'b0;
    end else if (!inRange) begin
      cnt_d = WIDTH'(clamp(CLAMP_W'(cnt_q), CLAMP_W'(lo_q), CLAMP_W'(hi_q)));
    end else if (tick) begin
      if (bus.updn_cnt) begin
        if (cnt_q < hi_q) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (bus.mode == MODE_WRAP) begin
          cnt_d = lo_q;
          tc_d  = 1'b1;
        end else begin
          tc_d      = !holdEff;
          satHold_d = 1'b1;
        end
      end else begin
        if (cnt_q > lo_q) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (bus.mode == MODE_WRAP) begin
          cnt_d = hi_q;
          tc_d  = 1'b1;
        end else begin
          tc_d      = !holdEff;
          satHold_d = 1'b1;
        end
      end
    end

    // Limits change only at the end of the cycle, so this cycle's load/step used the old ones.
    if (bus.lim_wr) begin
      if (bus.lim_lo_in <= bus.lim_hi_in) begin
        lo_d = bus.lim_lo_in;
        hi_d = bus.lim_hi_in;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q     <= RST_LO;
      lo_q      <= RST_LO;
      hi_q      <= RST_HI;
      tc_q      <= 1'b0;
      err_q     <= 1'b0;
      satHold_q <= 1'b0;
      dir_q     <= 1'b1;
      mode_q    <= MODE_WRAP;
    end else begin
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      tc_q      <= tc_d;
      err_q     <= err_d;
      satHold_q <= satHold_d;
      dir_q     <= bus.updn_cnt;
      mode_q    <= bus.mode;
    end
  end

  assign bus.data_out = cnt_q;
  assign bus.at_max   = (cnt_q == hi_q);
  assign bus.at_min   = (cnt_q == lo_q);
  assign bus.tc       = tc_q;
  assign bus.lim_err  = err_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Randomised and directed bench for updown_counter_param against an arithmetic reference model.
// Exercises the prescaler as well when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_param;
  import counter_pkg::*;

  localparam int          WIDTH   = 16;
  localparam int          PRESC_W = 4;
  localparam int unsigned MASK    = 32'h0000_FFFF;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;

  int checkCount = 0;
  int passCount  = 0;

  int unsigned mCnt, mLo, mHi, mPresc;
  bit          mTc, mErr, mSat, mPrevDir, mPrevMode;
  int unsigned pDiv = 0;

  int t2Cnt [5] = '{6, 7, 7, 7, 7};
  int t2Tc  [5] = '{0, 0, 1, 0, 0};

`ifdef COUNTER_PRESCALE_EN
  updown_counter_param_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();
`else
  updown_counter_param_if #(.WIDTH(WIDTH)) bus ();
`endif

  updown_counter_param #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  function automatic int unsigned clampI(input int unsigned v, input int unsigned lo, input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic modelReset();
    mCnt = 0; mLo = 0; mHi = MASK; mTc = 0; mErr = 0; mSat = 0;
    mPrevDir = 1; mPrevMode = 0; mPresc = 0;
  endtask

  // One clock edge of the counter's intended behaviour, in plain integer arithmetic.
  task automatic modelStep(input bit ld, input int unsigned din, input bit en, input bit up,
                           input bit md, input bit lw, input int unsigned llo, input int unsigned lhi);
    bit tick;
    if (up != mPrevDir || md != mPrevMode) mSat = 0;
    mPrevDir  = up;
    mPrevMode = md;
`ifdef COUNTER_PRESCALE_EN
    tick = 0;
    if (!ld) begin
      mPresc = 0;
    end else if (en) begin
      tick   = (mPresc == pDiv);
      mPresc = tick ? 0 : mPresc + 1;
    end
`else
    tick = en;
`endif
    mTc = 0;
    if (!ld) begin
      mCnt = clampI(din & MASK, mLo, mHi);
      mSat = 0;
    end else if (mCnt < mLo || mCnt > mHi) begin
      mCnt = clampI(mCnt, mLo, mHi);
    end else if (tick) begin
      if (up) begin
        if (mCnt < mHi) mCnt = mCnt + 1;
        else if (!md) begin mCnt = mLo; mTc = 1; end
        else begin mTc = !mSat; mSat = 1; end
      end else begin
        if (mCnt > mLo) mCnt = mCnt - 1;
        else if (!md) begin mCnt = mHi; mTc = 1; end
        else begin mTc = !mSat; mSat = 1; end
      end
    end
    if (lw) begin
      if ((llo & MASK) <= (lhi & MASK)) begin
        mLo = llo & MASK;
        mHi = lhi & MASK;
      end else begin
        mErr = 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit ld, input int unsigned din, input bit en, input bit up,
                               input bit md, input bit lw, input int unsigned llo, input int unsigned lhi);
    bus.ld_cnt    = ld;
    bus.data_in   = WIDTH'(din);
    bus.count_enb = en;
    bus.updn_cnt  = up;
    bus.mode      = mode_e'(md);
    bus.lim_wr    = lw;
    bus.lim_lo_in = WIDTH'(llo);
    bus.lim_hi_in = WIDTH'(lhi);
`ifdef COUNTER_PRESCALE_EN
    bus.presc_div = PRESC_W'(pDiv);
`endif
    @(posedge clk);
    modelStep(ld, din, en, up, md, lw, llo, lhi);
    #1;
    checkOutput("cnt",    32'(bus.data_out), mCnt);
    checkOutput("tc",     32'(bus.tc),       32'(mTc));
    checkOutput("atMax",  32'(bus.at_max),   32'(mCnt == mHi));
    checkOutput("atMin",  32'(bus.at_min),   32'(mCnt == mLo));
    checkOutput("limErr", 32'(bus.lim_err),  32'(mErr));
  endtask

  task automatic resetDut();
    rst_ = 1'b0;
    #2;
    checkOutput("rstCnt",    32'(bus.data_out), 0);
    checkOutput("rstTc",     32'(bus.tc),       0);
    checkOutput("rstLimErr", 32'(bus.lim_err),  0);
    checkOutput("rstAtMin",  32'(bus.at_min),   1);
    checkOutput("rstAtMax",  32'(bus.at_max),   0);
    modelReset();
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    bus.ld_cnt = 1'b1; bus.data_in = '0; bus.count_enb = 1'b0; bus.updn_cnt = 1'b1;
    bus.mode = MODE_WRAP; bus.lim_wr = 1'b0; bus.lim_lo_in = '0; bus.lim_hi_in = '0;
`ifdef COUNTER_PRESCALE_EN
    bus.presc_div = '0;
`endif
    #1;
    resetDut();

    // Full-range wrap from reset.
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
      if (i == 65534) checkOutput("t1Top", 32'(bus.data_out), 32'hFFFF);
    end
    checkOutput("t1WrapCnt", 32'(bus.data_out), 0);
    checkOutput("t1WrapTc",  32'(bus.tc),       1);
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("t1TcDrop", 32'(bus.tc), 0);

    // Saturation with a single tc pulse, then a direction change.
    applyStimulus(1, 0, 0, 1, 1, 1, 3, 7);
    applyStimulus(0, 5, 0, 1, 1, 0, 0, 0);
    checkOutput("t2Load", 32'(bus.data_out), 5);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 1, 1, 1, 0, 0, 0);
      checkOutput("t2Cnt", 32'(bus.data_out), 32'(t2Cnt[i]));
      checkOutput("t2Tc",  32'(bus.tc),       32'(t2Tc[i]));
    end
    applyStimulus(1, 0, 1, 0, 1, 0, 0, 0);
    checkOutput("t2Down", 32'(bus.data_out), 6);

    // Wrap downward and clamped loads.
    applyStimulus(0, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("t3WrapCnt", 32'(bus.data_out), 7);
    checkOutput("t3WrapTc",  32'(bus.tc),       1);
    applyStimulus(0, 9, 0, 0, 0, 0, 0, 0);
    checkOutput("t3ClampHi", 32'(bus.data_out), 7);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("t3ClampLo", 32'(bus.data_out), 3);

    // Limit shrink clamps on the following edge; an illegal write latches lim_err.
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 20);
    applyStimulus(0, 10, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 4);
    checkOutput("t4Before", 32'(bus.data_out), 10);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4Clamped", 32'(bus.data_out), 4);
    applyStimulus(1, 0, 0, 0, 0, 1, 8, 2);
    checkOutput("t4Err",     32'(bus.lim_err), 1);
    checkOutput("t4LimKept", 32'(bus.at_max),  1);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("t4ErrSticky", 32'(bus.lim_err), 1);

    // Load beats step; asynchronous reset mid-count.
    applyStimulus(1, 0, 0, 1, 0, 1, 0, 50);
    applyStimulus(0, 20, 1, 1, 0, 0, 0, 0);
    checkOutput("t5Load",   32'(bus.data_out), 20);
    checkOutput("t5LoadTc", 32'(bus.tc),       0);
    repeat (3) applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    resetDut();
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("t5Resume", 32'(bus.data_out), 1);

`ifdef COUNTER_PRESCALE_EN
    // Every third enabled cycle steps; disabled cycles do not advance the prescaler.
    pDiv = 2;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    foreach (t2Cnt[i]) applyStimulus(1, 0, (i != 3), 1, 0, 0, 0, 0);
    repeat (4) applyStimulus(1, 0, 1, 1, 0, 0, 0, 0);
    checkOutput("t6Presc", 32'(bus.data_out), 2);
    pDiv = 0;
`endif

    // Random traffic in small windows so limits and saturation are hit often.
    applyStimulus(1, 0, 0, 1, 0, 1, 5, 12);
    begin
      bit up = 1, md = 0;
      for (int i = 0; i < 3000; i++) begin
        bit ld, en, lw;
        int unsigned lo, hi;
        ld = ($urandom_range(0, 11) != 0);
        en = ($urandom_range(0, 4) != 0);
        lw = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 9) == 0) up = ~up;
        if ($urandom_range(0, 19) == 0) md = ~md;
        lo = $urandom_range(0, 30);
        hi = lo + $urandom_range(0, 15);
        if ($urandom_range(0, 19) == 0) begin
          int unsigned t;
          t = lo; lo = hi + 1; hi = t;
        end
`ifdef COUNTER_PRESCALE_EN
        if ($urandom_range(0, 49) == 0) pDiv = $urandom_range(0, 3);
`endif
        applyStimulus(ld, $urandom_range(0, 50), en, up, md, lw, lo, hi);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
